// File: rtl/redstone_tick_sched.sv
// redstone_tick_sched: derives the game tick from the system clock, sequences
// netlist input latching and output capture, and runs/pauses/steps under a
// host command handshake.
// Build option: define REDSTONE_TICK_SCHED_SYNC_EN to pass i_pins through a
// 2-flop synchronizer before the input latch. Leave it undefined for
// synchronous sources.
module redstone_tick_sched #(
  parameter int unsigned CLK_DIV = 5000000,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned N_IN    = 10,
  parameter int unsigned N_OUT   = 10,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd,
  input  logic [15:0]      i_cmd_arg,
  input  logic [N_IN-1:0]  i_pins,
  output logic [N_IN-1:0]  o_rs_in,
  output logic             o_tick,
  input  logic [N_OUT-1:0] i_rs_out,
  output logic [N_OUT-1:0] o_rs_out,
  output logic             o_out_valid,
  output logic             o_running,
  output logic [CNT_W-1:0] o_tick_count
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned SET_W = $clog2(SETTLE + 1);

  localparam logic [1:0] CMD_PAUSE = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [15:0]      rem;
  logic [SET_W-1:0] cap_cnt;
  logic [N_IN-1:0]  pins_s;
  logic             accept;
  logic             pause_acc;
  logic             clear_acc;
  logic             tick_fire;

`ifdef REDSTONE_TICK_SCHED_SYNC_EN
  logic [N_IN-1:0] sync1;
  logic [N_IN-1:0] sync2;

  // Two-flop synchronizer for asynchronous board pins
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_pins;
      sync2 <= sync1;
    end
  end

  assign pins_s = sync2;
`else
  assign pins_s = i_pins;
`endif

  // Command acceptance and tick decision; a PAUSE on the last divider slot wins
  always_comb begin
    accept    = i_cmd_valid && o_cmd_ready;
    pause_acc = accept && (i_cmd == CMD_PAUSE);
    clear_acc = accept && (i_cmd == CMD_CLEAR);
    tick_fire = (state != PAUSED) && (div == DIV_W'(CLK_DIV - 1)) && !pause_acc;
  end

  // Tick divider: free-runs while active, held at 0 when paused or stopping
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div <= '0;
    end else if ((state == PAUSED) || pause_acc || tick_fire) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Run/pause/step state machine with its registered status outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= PAUSED;
      rem         <= '0;
      o_running   <= 1'b0;
      o_cmd_ready <= 1'b1;
    end else begin
      case (state)
        PAUSED: begin
          if (accept && (i_cmd == CMD_RUN)) begin
            state     <= RUN;
            o_running <= 1'b1;
          end else if (accept && (i_cmd == CMD_STEP) && (i_cmd_arg != 16'd0)) begin
            state       <= STEP;
            rem         <= i_cmd_arg;
            o_running   <= 1'b1;
            o_cmd_ready <= 1'b0;
          end
        end
        RUN: begin
          if (pause_acc) begin
            state     <= PAUSED;
            o_running <= 1'b0;
          end
        end
        STEP: begin
          if (tick_fire) begin
            rem <= rem - 16'd1;
            if (rem == 16'd1) begin
              state       <= PAUSED;
              o_running   <= 1'b0;
              o_cmd_ready <= 1'b1;
            end
          end
        end
        default: begin
          state       <= PAUSED;
          o_running   <= 1'b0;
          o_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Tick pulse, tick counter, input latch and delayed output capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_tick       <= 1'b0;
      o_tick_count <= '0;
      o_rs_in      <= '0;
      o_rs_out     <= '0;
      o_out_valid  <= 1'b0;
      cap_cnt      <= '0;
    end else begin
      o_tick      <= tick_fire;
      o_out_valid <= (cap_cnt == SET_W'(1));

      if (clear_acc) begin
        o_tick_count <= '0;
      end else if (tick_fire) begin
        o_tick_count <= o_tick_count + CNT_W'(1);
      end

      if (div == DIV_W'(CLK_DIV - 2)) begin
        o_rs_in <= pins_s;
      end

      if (tick_fire) begin
        cap_cnt <= SET_W'(SETTLE);
      end else if (cap_cnt != '0) begin
        cap_cnt <= cap_cnt - SET_W'(1);
      end

      if (cap_cnt == SET_W'(1)) begin
        o_rs_out <= i_rs_out;
      end
    end
  end

endmodule
